// File: rtl/mult_argmax_sequencer_if.sv
// Sequencer bundle: start/result side plus the multiplier row handshake.
// slave is the sequencer; master is the multiplier/host environment.
interface mult_argmax_sequencer_if;
  logic        start;
  logic        done_row;
  logic [15:0] row_result;
  logic        overflow;
  logic [3:0]  row_select;
  logic        begin_mult;
  logic        busy;
  logic        result_valid;
  logic [3:0]  digit;
  logic [15:0] max_score;
  logic        overflow_seen;
  logic        timeout_err;

  modport master (
    output start, done_row, row_result, overflow,
    input  row_select, begin_mult, busy, result_valid,
    input  digit, max_score, overflow_seen, timeout_err
  );

  modport slave (
    input  start, done_row, row_result, overflow,
    output row_select, begin_mult, busy, result_valid,
    output digit, max_score, overflow_seen, timeout_err
  );
endinterface

// File: rtl/mult_argmax_sequencer.sv
// Walks the weight rows through the multiplier and keeps a signed argmax.
// Reports winning row, saturated score, overflow and watchdog status.
module mult_argmax_sequencer #(
  parameter int NUM_ROWS       = 10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                    clk,
  input logic                    n_rst,
  mult_argmax_sequencer_if.slave bus
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic             first_q, first_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [3:0]       digit_q, digit_d;
  logic [15:0]      max_q, max_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [15:0]      score;
  logic             take;

  // Overflowed rows saturate positive so they always look strong.
  assign score = bus.overflow ? 16'h7FFF : bus.row_result;
  assign take  = first_q || ($signed(score) > $signed(max_q));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      first_q <= 1'b1;
      wd_q    <= '0;
      digit_q <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      first_q <= first_d;
      wd_q    <= wd_d;
      digit_q <= digit_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    first_d = first_q;
    wd_d    = wd_q;
    digit_d = digit_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          row_d   = '0;
          first_d = 1'b1;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + WDW'(1);
        // A capture in the expiry cycle beats the watchdog.
        if (bus.done_row) begin
          if (take) begin
            max_d   = score;
            digit_d = row_q;
            first_d = 1'b0;
          end
          ovf_d = ovf_q | bus.overflow;
          if (row_q == LAST_ROW) begin
            state_d = FINISH;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = ISSUE;
          end
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.row_select    = row_q;
  assign bus.begin_mult    = (state_q == ISSUE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.result_valid  = (state_q == FINISH);
  assign bus.digit         = digit_q;
  assign bus.max_score     = max_q;
  assign bus.overflow_seen = ovf_q;
  assign bus.timeout_err   = tmo_q;

endmodule

// File: tb/tb_mult_argmax_sequencer.sv
// Directed bench for mult_argmax_sequencer: multiplier responder,
// argmax model per run and a per-cycle compare process.
module tb_mult_argmax_sequencer;

  localparam int NROWS = 10;
  localparam int TO1   = 1023;
  localparam int TO2   = 50;
  localparam int RUN_BUDGET = 6000;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  mult_argmax_sequencer_if if1();
  mult_argmax_sequencer_if if2();

  logic        start_r   = 1'b0;
  logic        resp_done = 1'b0;
  logic        resp_ovf  = 1'b0;
  logic        spur_done = 1'b0;
  logic [15:0] resp_val  = '0;

  assign if1.start      = start_r;
  assign if1.done_row   = resp_done | spur_done;
  assign if1.row_result = spur_done ? 16'h7FFF : resp_val;
  assign if1.overflow   = spur_done | resp_ovf;
  assign if2.start      = if1.start;
  assign if2.done_row   = if1.done_row;
  assign if2.row_result = if1.row_result;
  assign if2.overflow   = if1.overflow;

  mult_argmax_sequencer #(
    .NUM_ROWS(NROWS), .TIMEOUT_CYCLES(TO1)
  ) u_dut (.clk(clk), .n_rst(n_rst), .bus(if1));

  mult_argmax_sequencer #(
    .NUM_ROWS(NROWS), .TIMEOUT_CYCLES(TO2)
  ) u_dut2 (.clk(clk), .n_rst(n_rst), .bus(if2));

  // stimulus tables and model outputs (driver-owned)
  int          scores[16];
  bit          ovfs[16];
  int          skip_row = -1;
  int          lat = 4;
  int          exp_rows, exp_digit;
  logic [15:0] exp_max;
  bit          exp_ovf, exp_to;
  int          lit_digit, lit_max;
  bit          lit_ovf, lit_to;
  int          prev_digit = 0;
  logic [15:0] prev_max = '0;
  bit          t2_arm = 1'b0;

  // compare-owned state
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          run_open = 1'b0;
  int          start_cyc, bm_cnt, last_bm_cyc, done_cyc, last_bm2_cyc;
  int          hold_digit = 0;
  logic [15:0] hold_max = '0;
  bit          hold_ovf = 1'b0, hold_to = 1'b0;
  bit          t2_seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  // Expected outcome of one classification straight from the row tables.
  task automatic model_run();
    int best;
    int s;
    bit got;
    got = 0; best = 0;
    exp_rows = NROWS; exp_to = 0; exp_ovf = 0;
    exp_digit = prev_digit; exp_max = prev_max;
    for (int r = 0; r < NROWS; r++) begin
      if (r == skip_row) begin
        exp_to = 1; exp_rows = r + 1;
        break;
      end
      s = ovfs[r] ? 32767 : scores[r];
      if (!got || s > best) begin
        best = s; exp_digit = r; got = 1;
      end
      exp_ovf |= ovfs[r];
    end
    if (got) exp_max = 16'(best);
  endtask

  // multiplier model: answers each begin_mult after lat cycles
  initial begin : responder
    int r;
    bit ab;
    forever begin
      @(negedge clk);
      if (n_rst && if1.begin_mult) begin
        r = int'(if1.row_select);
        ab = 0;
        if (r != skip_row) begin
          for (int k = 0; k < lat; k++) begin
            @(posedge clk);
            if (!n_rst) ab = 1;
          end
          if (!ab) begin
            #1;
            resp_done = 1'b1;
            resp_val  = 16'(scores[r]);
            resp_ovf  = ovfs[r];
            @(posedge clk);
            #1;
            resp_done = 1'b0;
            resp_ovf  = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if2.begin_mult) last_bm2_cyc = cyc;
    if (t2_arm && !t2_seen && if2.result_valid) begin
      t2_seen = 1'b1;
      chk("t2_latency", cyc - last_bm2_cyc, TO2 + 1);
      chk("t2_digit", 32'(if2.digit), 5);
      chk("t2_max", 32'(if2.max_score), 5);
      chk("t2_timeout", 32'(if2.timeout_err), 1);
      chk("t2_ovf", 32'(if2.overflow_seen), 0);
      chk("t2_busy", 32'(if2.busy), 1);
    end
    if (!n_rst) begin
      run_open = 1'b0; bm_cnt = 0;
      hold_digit = 0; hold_max = '0; hold_ovf = 0; hold_to = 0;
      chk("rst_busy", 32'(if1.busy), 0);
      chk("rst_begin", 32'(if1.begin_mult), 0);
      chk("rst_valid", 32'(if1.result_valid), 0);
      chk("rst_rowsel", 32'(if1.row_select), 0);
      chk("rst_digit", 32'(if1.digit), 0);
      chk("rst_max", 32'(if1.max_score), 0);
      chk("rst_ovf", 32'(if1.overflow_seen), 0);
      chk("rst_to", 32'(if1.timeout_err), 0);
    end else if (!run_open) begin
      chk("idle_begin", 32'(if1.begin_mult), 0);
      chk("idle_valid", 32'(if1.result_valid), 0);
      chk("idle_busy", 32'(if1.busy), 0);
      chk("idle_digit", 32'(if1.digit), hold_digit);
      chk("idle_max", 32'(if1.max_score), 32'(hold_max));
      chk("idle_ovf", 32'(if1.overflow_seen), 32'(hold_ovf));
      chk("idle_to", 32'(if1.timeout_err), 32'(hold_to));
      if (if1.start) begin
        run_open = 1'b1; start_cyc = cyc; bm_cnt = 0;
        last_bm_cyc = cyc; done_cyc = cyc;
      end
    end else begin
      if (cyc > start_cyc) chk("run_busy", 32'(if1.busy), 1);
      if (if1.begin_mult) begin
        chk("row_select", 32'(if1.row_select), bm_cnt);
        if (bm_cnt == 0) chk("issue_lat", cyc - start_cyc, 1);
        else chk("issue_lat", cyc - done_cyc, 1);
        bm_cnt++;
        last_bm_cyc = cyc;
      end
      if (if1.done_row) done_cyc = cyc;
      if (if1.result_valid) begin
        chk("model_digit", exp_digit, lit_digit);
        chk("model_max", 32'(exp_max), lit_max);
        chk("model_ovf", 32'(exp_ovf), 32'(lit_ovf));
        chk("model_to", 32'(exp_to), 32'(lit_to));
        chk("digit", 32'(if1.digit), exp_digit);
        chk("max_score", 32'(if1.max_score), 32'(exp_max));
        chk("overflow_seen", 32'(if1.overflow_seen), 32'(exp_ovf));
        chk("timeout_err", 32'(if1.timeout_err), 32'(exp_to));
        chk("begin_count", bm_cnt, exp_rows);
        if (exp_to) begin
          chk("valid_lat", cyc - last_bm_cyc, TO1 + 1);
          chk("t2_result_seen", 32'(t2_seen), 1);
        end else begin
          chk("valid_lat", cyc - done_cyc, 1);
        end
        run_open = 1'b0;
        hold_digit = exp_digit; hold_max = exp_max;
        hold_ovf = exp_ovf; hold_to = exp_to;
      end else if (cyc - start_cyc > RUN_BUDGET) begin
        chk("run_budget", 32'(if1.result_valid), 1);
        run_open = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start_r = 1'b1;
    @(posedge clk); #1 start_r = 1'b0;
  endtask

  task automatic run(input int l, input int ld, input int lm,
                     input bit lo, input bit lt, input bit spur);
    lat = l;
    model_run();
    lit_digit = ld; lit_max = lm; lit_ovf = lo; lit_to = lt;
    pulse_start();
    if (spur) begin
      repeat (100) @(posedge clk);
      pulse_start();
    end
    repeat (2) @(posedge clk);
    while (run_open) @(posedge clk);
    prev_digit = exp_digit; prev_max = exp_max;
    repeat (5) @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    #1 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (3) @(posedge clk);

    // ties at 20 resolve to the lower row; stray start mid-run
    scores = '{5, 20, -3, 20, 7, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
    ovfs = '{default: 1'b0};
    run(400, 1, 20, 0, 0, 1);

    // stray done_row while idle
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    repeat (4) @(posedge clk);

    for (int r = 0; r < 16; r++) scores[r] = -100;
    scores[9] = -1;
    run(3, 9, 32'hFFFF, 0, 0, 0);

    scores = '{10, 999, -5, 300, -32767, 7, 998, 0, 1, 2,
               0, 0, 0, 0, 0, 0};
    ovfs[4] = 1'b1;
    run(5, 4, 32'h7FFF, 1, 0, 0);
    ovfs[4] = 1'b0;

    for (int r = 0; r < 16; r++) scores[r] = r;
    skip_row = 6;
    t2_arm = 1'b1;
    run(10, 5, 5, 0, 1, 0);
    skip_row = -1;

    // reset while waiting on row 3, then a clean run
    for (int r = 0; r < 16; r++) scores[r] = 3 * r;
    lat = 20;
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (if1.begin_mult && if1.row_select == 4'd3) break;
    end
    repeat (5) @(posedge clk);
    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    prev_digit = 0; prev_max = '0;
    repeat (30) @(posedge clk);
    run(20, 9, 27, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
